// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: physical/architectural tags and the renamed packet
// handed from rename to dispatch and the ROB.
package ooo_pkg;

  localparam int unsigned DEF_NUM_PREGS = 64;
  localparam int unsigned PREG_W        = $clog2(DEF_NUM_PREGS);
  localparam int unsigned NUM_AREGS     = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;

  typedef struct packed {
    preg_t       prs1;
    preg_t       prs2;
    preg_t       prd;
    preg_t       old_prd;
    areg_t       rd;
    logic [2:0]  aluop;
    logic [6:0]  opcode;
    logic        fu_mem;
    logic        fu_alu;
    logic        fu_br;
    logic [31:0] imm;
    logic [31:0] pc;
  } rename_pkt_t;

endpackage

// File: rtl/rename_stage_free_list.sv
// Bit-vector free list of physical registers: lowest-index allocation, commit frees,
// and wholesale restore from the committed map on flush.
module rename_stage_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  localparam int unsigned PREG_W   = $clog2(NUM_PREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  output logic [PREG_W-1:0]    alloc_preg,
  input  logic                 free_valid,
  input  logic [PREG_W-1:0]    free_preg,
  input  logic                 restore,
  input  logic [NUM_PREGS-1:0] restore_mask,
  output logic [PREG_W:0]      free_count
);

  logic [NUM_PREGS-1:0] free_q;
  logic [NUM_PREGS-1:0] free_d;
  logic [PREG_W:0]      count_q;
  logic [PREG_W:0]      count_d;

  // Descending scan so the lowest set bit wins; preg 0 is never a candidate.
  always_comb begin
    alloc_preg = '0;
    for (int i = int'(NUM_PREGS) - 1; i > 0; i--) begin
      if (free_q[i]) alloc_preg = PREG_W'(i);
    end
  end

  always_comb begin
    free_d = free_q;
    if (restore) begin
      free_d = ~restore_mask;
    end else begin
      if (alloc)      free_d[alloc_preg] = 1'b0;
      if (free_valid) free_d[free_preg]  = 1'b1;
    end
    free_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(NUM_PREGS); i++) begin
      count_d = count_d + (PREG_W+1)'(free_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q  <= {{(NUM_PREGS-32){1'b1}}, 32'b0};
      count_q <= (PREG_W+1)'(NUM_PREGS - 32);
    end else begin
      free_q  <= free_d;
      count_q <= count_d;
    end
  end

  assign free_count = count_q;

endmodule

// File: rtl/rename_stage.sv
// Register rename: SRAT lookup for sources, free-list allocation for the destination,
// CRAT update on commit, SRAT/free-list restore on flush, one-entry output buffer.
module rename_stage
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_PREGS = DEF_NUM_PREGS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  areg_t       in_rs1,
  input  areg_t       in_rs2,
  input  areg_t       in_rd,
  input  logic [2:0]  in_aluop,
  input  logic [6:0]  in_opcode,
  input  logic        in_fu_mem,
  input  logic        in_fu_alu,
  input  logic        in_fu_br,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output rename_pkt_t out_pkt,
  input  logic        commit_valid,
  input  areg_t       commit_rd,
  input  preg_t       commit_prd,
  input  preg_t       commit_old_prd,
  input  logic        flush,
  output logic [PREG_W:0] free_count
);

  preg_t                srat_q [NUM_AREGS];
  preg_t                crat_q [NUM_AREGS];
  preg_t                crat_d [NUM_AREGS];
  logic [NUM_PREGS-1:0] crat_mask;
  logic                 need_alloc, fire_in, fire_out, alloc, commit_en;
  preg_t                alloc_preg;
  logic                 out_valid_q;
  rename_pkt_t          out_pkt_q, pkt_d;

  assign need_alloc = (in_rd != '0);
  assign in_ready   = (~out_valid_q | out_ready) & (~need_alloc | (free_count != '0)) & ~flush;
  assign fire_in    = in_valid & in_ready;
  assign fire_out   = out_valid_q & out_ready;
  assign alloc      = fire_in & need_alloc;
  assign commit_en  = commit_valid & (commit_rd != '0);

  // Committed map including this cycle's retirement, so a same-cycle flush sees it.
  always_comb begin
    crat_d = crat_q;
    if (commit_en) crat_d[commit_rd] = commit_prd;
  end

  always_comb begin
    crat_mask = '0;
    for (int i = 0; i < int'(NUM_AREGS); i++) crat_mask[crat_d[i]] = 1'b1;
  end

  always_comb begin
    pkt_d         = '0;
    pkt_d.prs1    = (in_rs1 == '0) ? '0 : srat_q[in_rs1];
    pkt_d.prs2    = (in_rs2 == '0) ? '0 : srat_q[in_rs2];
    pkt_d.prd     = need_alloc ? alloc_preg : '0;
    pkt_d.old_prd = need_alloc ? srat_q[in_rd] : '0;
    pkt_d.rd      = in_rd;
    pkt_d.aluop   = in_aluop;
    pkt_d.opcode  = in_opcode;
    pkt_d.fu_mem  = in_fu_mem;
    pkt_d.fu_alu  = in_fu_alu;
    pkt_d.fu_br   = in_fu_br;
    pkt_d.imm     = in_imm;
    pkt_d.pc      = in_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_AREGS); i++) begin
        srat_q[i] <= preg_t'(i);
        crat_q[i] <= preg_t'(i);
      end
    end else begin
      crat_q <= crat_d;
      if (flush) begin
        srat_q <= crat_d;
      end else if (alloc) begin
        srat_q[in_rd] <= alloc_preg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (fire_in) begin
      out_valid_q <= 1'b1;
      out_pkt_q   <= pkt_d;
    end else if (fire_out) begin
      out_valid_q <= 1'b0;
    end
  end

  rename_stage_free_list #(
    .NUM_PREGS (NUM_PREGS)
  ) u_free_list (
    .clk          (clk),
    .reset        (reset),
    .alloc        (alloc),
    .alloc_preg   (alloc_preg),
    .free_valid   (commit_en),
    .free_preg    (commit_old_prd),
    .restore      (flush),
    .restore_mask (crat_mask),
    .free_count   (free_count)
  );

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;

endmodule
